// File: rtl/alu_console.sv
// Single-step ALU console: a debounced step button walks operand A, operand B/opcode,
// execute and show phases. Optional accumulate mode is enabled by ALU_CONSOLE_ACC_EN.
module alu_console #(
  parameter int WIDTH      = 8,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sw,
  input  logic        btn_step,
  output logic [15:0] led
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] DEB_PRE = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {S_A, S_B, S_EXEC, S_SHOW} state_t;

  state_t             state_q, state_d;
  logic               btn_meta_q, btn_sync_q;
  logic [CNT_W-1:0]   deb_cnt_q, deb_cnt_d;
  logic               step;
  logic [WIDTH-1:0]   reg_a_q, reg_a_d;
  logic [WIDTH-1:0]   reg_b_q, reg_b_d;
  logic [3:0]         reg_op_q, reg_op_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [3:0]         flags_q, flags_d;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH:0]     sum_w, diff_w;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;
  logic [3:0]         state_oh;
  logic [7:0]         led_data;
  logic               unused_sw;

  // Only the operand, opcode and accumulate bits matter; the rest are deliberately ignored.
  assign unused_sw = ^sw;

  // Step fires on the cycle the count is about to reach DEB_CYCLES; saturation blocks repeats.
  assign step = btn_sync_q && (deb_cnt_q == DEB_PRE);

  always_comb begin
    if (!btn_sync_q)
      deb_cnt_d = '0;
    else if (deb_cnt_q != DEB_MAX)
      deb_cnt_d = deb_cnt_q + CNT_W'(1);
    else
      deb_cnt_d = deb_cnt_q;
  end

`ifdef ALU_CONSOLE_ACC_EN
  logic acc_sel_q, acc_sel_d;
  assign op_a = acc_sel_q ? result_q : reg_a_q;
`else
  assign op_a = reg_a_q;
`endif

  assign sum_w  = {1'b0, op_a} + {1'b0, reg_b_q};
  assign diff_w = {1'b0, op_a} - {1'b0, reg_b_q};

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (reg_op_q)
      4'd0: begin
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
        alu_v   = (op_a[WIDTH-1] == reg_b_q[WIDTH-1]) && (sum_w[WIDTH-1] != op_a[WIDTH-1]);
      end
      4'd1: begin
        alu_res = diff_w[WIDTH-1:0];
        alu_c   = diff_w[WIDTH];
        alu_v   = (op_a[WIDTH-1] != reg_b_q[WIDTH-1]) && (diff_w[WIDTH-1] != op_a[WIDTH-1]);
      end
      4'd2: alu_res = op_a & reg_b_q;
      4'd3: alu_res = op_a | reg_b_q;
      4'd4: alu_res = op_a ^ reg_b_q;
      4'd5: alu_res = ~op_a;
      4'd6: begin
        alu_res = {op_a[WIDTH-2:0], 1'b0};
        alu_c   = op_a[WIDTH-1];
      end
      4'd7: begin
        alu_res = {1'b0, op_a[WIDTH-1:1]};
        alu_c   = op_a[0];
      end
      4'd8:    alu_res = reg_b_q;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    reg_a_d  = reg_a_q;
    reg_b_d  = reg_b_q;
    reg_op_d = reg_op_q;
    result_d = result_q;
    flags_d  = flags_q;
`ifdef ALU_CONSOLE_ACC_EN
    acc_sel_d = acc_sel_q;
`endif
    case (state_q)
      S_A: if (step) begin
        reg_a_d = sw[WIDTH-1:0];
        state_d = S_B;
      end
      S_B: if (step) begin
        reg_b_d  = sw[WIDTH-1:0];
        reg_op_d = sw[11:8];
`ifdef ALU_CONSOLE_ACC_EN
        acc_sel_d = sw[15];
`endif
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        result_d = alu_res;
        flags_d  = {alu_c, (alu_res == '0), alu_res[WIDTH-1], alu_v};
        state_d  = S_SHOW;
      end
      S_SHOW: if (step) state_d = S_A;
      default: state_d = S_A;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments, and every register, including the
  // synchroniser and debounce counter, is cleared by reset so a reset mid-execute commits nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_A;
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      deb_cnt_q  <= '0;
      reg_a_q    <= '0;
      reg_b_q    <= '0;
      reg_op_q   <= '0;
      result_q   <= '0;
      flags_q    <= '0;
`ifdef ALU_CONSOLE_ACC_EN
      acc_sel_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      btn_meta_q <= btn_step;
      btn_sync_q <= btn_meta_q;
      deb_cnt_q  <= deb_cnt_d;
      reg_a_q    <= reg_a_d;
      reg_b_q    <= reg_b_d;
      reg_op_q   <= reg_op_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
`ifdef ALU_CONSOLE_ACC_EN
      acc_sel_q  <= acc_sel_d;
`endif
    end
  end

  always_comb begin
    led_data = '0;
    led_data[WIDTH-1:0] = (state_q == S_SHOW) ? result_q : sw[WIDTH-1:0];
    case (state_q)
      S_A:     state_oh = 4'b0001;
      S_B:     state_oh = 4'b0010;
      S_EXEC:  state_oh = 4'b0100;
      S_SHOW:  state_oh = 4'b1000;
      default: state_oh = 4'b0000;
    endcase
    led = {flags_q, state_oh, led_data};
  end

endmodule

// File: doc/alu_console.md
ALU_CONSOLE -- requirements
Module: alu_console

Interface
REQ-001 SHALL have parameter WIDTH, default 8, datapath width (legal 4..8).
REQ-002 SHALL have parameter DEB_CYCLES, default 1000000, consecutive stable-high clocks required to accept a button press (legal >= 2).
REQ-003 SHALL have port clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port sw  input  16  switches: sw[WIDTH-1:0] operand, sw[11:8] opcode, sw[15] accumulate select, other bits ignored.
REQ-006 SHALL have port btn_step  input  1  raw asynchronous step button.
REQ-007 SHALL have port led  output  16  led[15:12] flags {C,Z,N,V}, led[11:8] one-hot state, led[WIDTH-1:0] data, remaining bits 0.

Function
REQ-008 SHALL pass btn_step through a 2-flop synchroniser before any use.
REQ-009 SHALL count consecutive high cycles of the synchronised button, restarting at 0 on any low cycle and saturating at DEB_CYCLES.
REQ-010 SHALL emit one single-cycle step pulse on the cycle the count first reaches DEB_CYCLES; no further pulse until the button has been low for at least one cycle.
REQ-011 SHALL implement FSM states S_A, S_B, S_EXEC, S_SHOW, shown on led[8], led[9], led[10], led[11] respectively.
REQ-012 SHALL, in S_A on step, latch reg_a = sw[WIDTH-1:0] and move to S_B.
REQ-013 SHALL, in S_B on step, latch reg_b = sw[WIDTH-1:0] and reg_op = sw[11:8], and move to S_EXEC.
REQ-014 SHALL, in S_EXEC, register result and flags and move to S_SHOW unconditionally after exactly one cycle.
REQ-015 SHALL, in S_SHOW on step, move to S_A with result and flags held.
REQ-016 SHALL ignore step pulses in S_EXEC.
REQ-017 SHALL implement opcodes: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL A by 1, 7 SHR A by 1 (logical), 8 pass B; opcodes 9..15 give result 0.
REQ-018 SHALL set C = carry-out for ADD, borrow (A<B unsigned) for SUB, shifted-out bit for SHL/SHR, and 0 otherwise.
REQ-019 SHALL set Z = (result==0), N = result MSB, and V = signed overflow for ADD/SUB, 0 otherwise.
REQ-020 SHALL wrap result modulo 2^WIDTH.
REQ-021 SHALL drive led data = result in S_SHOW and live sw[WIDTH-1:0] in all other states.
REQ-022 SHALL drive flag LEDs from the registered flags in all states.

Reset
REQ-023 SHALL, on rst high at a clock edge, go to S_A and clear reg_a, reg_b, reg_op, result, flags, debounce count and synchroniser, overriding any step in the same cycle.
REQ-024 SHALL, after reset, drive led = {4'b0000, 4'b0001, 8'h00 padded, live switches in data field}.
REQ-025 SHALL give reset in any state, including S_EXEC, the same outcome, with no partial result committed.

Configuration
REQ-026 SHALL support macro ALU_CONSOLE_ACC_EN: when defined and sw[15]=1 at the S_B step, the A operand used in S_EXEC SHALL be the previous result instead of reg_a.
REQ-027 SHALL, when ALU_CONSOLE_ACC_EN is undefined, ignore sw[15] and always use reg_a as the A operand.

Verification (WIDTH=8, DEB_CYCLES=4)
REQ-028 SHALL cover: btn high 3 cycles then low -> no step, state stays S_A (led[11:8]=0001).
REQ-029 SHALL cover: A=0x7F, B=0x01, op=0, stable presses -> S_SHOW, led[7:0]=0x80, flags C0 Z0 N1 V1.
REQ-030 SHALL cover: A=0x05, B=0x05, op=1 -> result 0x00, flags C0 Z1 N0 V0; then A=0x03, B=0x05, op=1 -> 0xFE, C1 N1.
REQ-031 SHALL cover: A=0x81, op=6 -> 0x02, C1; then op=12 -> 0x00, Z1.
REQ-032 SHALL cover: rst asserted in S_B -> next cycle S_A, flags 0000, result 0, pending step ignored.
REQ-033 SHALL cover, with ALU_CONSOLE_ACC_EN: prior result 0x80, sw[15]=1, B=0x02, op=0 -> 0x82; without the macro, same stimulus with reg_a=0x10 -> 0x12.
